// File: rtl/move_player.sv
// Playback sequencer: steps through a solved move list and offers each move to the
// board over valid/ready. Optional macro MOVE_PLAYER_LOOP_EN repeats playback endlessly.
module move_player #(
    parameter int MAX_MOVES  = 22,
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comp,
    input  logic [4:0]             cnt,
    input  logic [2*MAX_MOVES-1:0] ord,
    input  logic                   btn_play,
    input  logic                   btn_step,
    input  logic                   btn_rew,
    output logic                   mv_valid,
    output logic [1:0]             mv_dir,
    output logic [4:0]             mv_idx,
    input  logic                   mv_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RUN_GAP = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [4:0]       MAX_LEN  = 5'(MAX_MOVES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [4:0]               idx_q, idx_d;
    logic [4:0]               len_q;
    logic [2*MAX_MOVES-1:0]   ord_q;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     pause_pend_q, pause_pend_d;
    logic                     rew_pend_q, rew_pend_d;
    logic                     step_mode_q, step_mode_d;
    logic                     btn_play_q, btn_step_q, btn_rew_q;
    logic                     mv_valid_q, mv_valid_d;
    logic [1:0]               mv_dir_q, mv_dir_d;
    logic [4:0]               mv_idx_q, mv_idx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     rew_ev, play_ev, step_ev, abort;
    logic                     xfer, rew_p, pause_p, pass_done;
    logic [4:0]               cnt_clamped, len_src, idx_next;
    logic [2*MAX_MOVES-1:0]   ord_src;
    logic [1:0]               move_src [MAX_MOVES];
    logic [1:0]               move_sel;

    // While idle the live inputs are used so the very first move comes from the current list.
    assign cnt_clamped = (cnt > MAX_LEN) ? MAX_LEN : cnt;
    assign len_src     = (state_q == S_IDLE) ? cnt_clamped : len_q;
    assign ord_src     = (state_q == S_IDLE) ? ord : ord_q;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_MOVES; gi++) begin : g_unpack
            assign move_src[gi] = ord_src[2*gi +: 2];
        end
    endgenerate

    assign rew_ev   = btn_rew & ~btn_rew_q;
    assign play_ev  = btn_play & ~btn_play_q & ~rew_ev;
    assign step_ev  = btn_step & ~btn_step_q & ~rew_ev & ~(btn_play & ~btn_play_q);
    assign abort    = rew_ev | ~comp;
    assign xfer     = mv_valid_q & mv_ready;
    assign rew_p    = rew_pend_q | rew_ev | ~comp;
    assign pause_p  = pause_pend_q | play_ev;
    assign idx_next = idx_q + 5'd1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        pause_pend_d = pause_pend_q;
        rew_pend_d   = rew_pend_q;
        step_mode_d  = step_mode_q;
        pass_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d        = 5'd0;
                gap_d        = '0;
                pause_pend_d = 1'b0;
                rew_pend_d   = 1'b0;
                step_mode_d  = 1'b0;
                if (comp && (play_ev || step_ev)) begin
                    if (len_src == 5'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_ISSUE;
                        step_mode_d = step_ev;
                    end
                end
            end
            S_ISSUE: begin
                if (!xfer) begin
                    rew_pend_d   = rew_p;
                    pause_pend_d = pause_p;
                end else begin
                    rew_pend_d   = 1'b0;
                    pause_pend_d = 1'b0;
                    step_mode_d  = 1'b0;
                    if (rew_p) begin
                        state_d = S_IDLE;
                        idx_d   = 5'd0;
                        gap_d   = '0;
                    end else if (idx_next == len_q) begin
`ifdef MOVE_PLAYER_LOOP_EN
                        pass_done = 1'b1;
                        idx_d     = 5'd0;
                        gap_d     = GAP_LOAD;
                        state_d   = (pause_p || step_mode_q) ? S_PAUSED : S_RUN_GAP;
`else
                        idx_d   = idx_next;
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_next;
                        gap_d   = GAP_LOAD;
                        state_d = (pause_p || step_mode_q) ? S_PAUSED : S_RUN_GAP;
                    end
                end
            end
            S_RUN_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                    gap_d   = '0;
                end else if (play_ev) begin
                    state_d = S_PAUSED;
                end else if (gap_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_PAUSED: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                    gap_d   = '0;
                end else if (play_ev) begin
                    state_d = S_RUN_GAP;
                end else if (step_ev) begin
                    state_d     = S_ISSUE;
                    step_mode_d = 1'b1;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                    gap_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 5'd0;
                gap_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values, so they track the state with no extra lag.
    always_comb begin
        move_sel = 2'b00;
        for (int i = 0; i < MAX_MOVES; i++) begin
            if (idx_d == 5'(i)) move_sel = move_src[i];
        end
        mv_valid_d = (state_d == S_ISSUE);
        mv_dir_d   = (state_d == S_ISSUE) ? move_sel : mv_dir_q;
        mv_idx_d   = idx_d;
        busy_d     = (state_d == S_ISSUE) || (state_d == S_RUN_GAP) || (state_d == S_PAUSED);
        done_d     = (state_d == S_DONE) || pass_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            len_q        <= 5'd0;
            ord_q        <= '0;
            gap_q        <= '0;
            pause_pend_q <= 1'b0;
            rew_pend_q   <= 1'b0;
            step_mode_q  <= 1'b0;
            btn_play_q   <= 1'b0;
            btn_step_q   <= 1'b0;
            btn_rew_q    <= 1'b0;
            mv_valid_q   <= 1'b0;
            mv_dir_q     <= 2'b00;
            mv_idx_q     <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            pause_pend_q <= pause_pend_d;
            rew_pend_q   <= rew_pend_d;
            step_mode_q  <= step_mode_d;
            btn_play_q   <= btn_play;
            btn_step_q   <= btn_step;
            btn_rew_q    <= btn_rew;
            mv_valid_q   <= mv_valid_d;
            mv_dir_q     <= mv_dir_d;
            mv_idx_q     <= mv_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            if (state_q == S_IDLE) begin
                ord_q <= ord;
                len_q <= cnt_clamped;
            end
        end
    end

    assign mv_valid = mv_valid_q;
    assign mv_dir   = mv_dir_q;
    assign mv_idx   = mv_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_move_player.sv
// Directed bench for move_player: each task drives one scenario and checks inline.
module tb_move_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        comp = 1'b0;
    logic [4:0]  cnt = 5'd0;
    logic [43:0] ord = '0;
    logic        btn_play = 1'b0;
    logic        btn_step = 1'b0;
    logic        btn_rew = 1'b0;
    logic        mv_ready = 1'b0;
    logic        mv_valid;
    logic [1:0]  mv_dir;
    logic [4:0]  mv_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         x_edge [$];
    logic [1:0] x_dir  [$];
    logic [4:0] x_idx  [$];
    int         r_edge [$];
    logic       prev_valid = 1'b0;

    move_player dut (
        .clk(clk), .rst_n(rst_n), .comp(comp), .cnt(cnt), .ord(ord),
        .btn_play(btn_play), .btn_step(btn_step), .btn_rew(btn_rew),
        .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_idx(mv_idx),
        .mv_ready(mv_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer log: a transfer seen at this negedge happens on the next rising edge.
    always @(negedge clk) begin
        if (mv_valid && !prev_valid) r_edge.push_back(cyc);
        if (mv_valid && mv_ready) begin
            x_edge.push_back(cyc + 1);
            x_dir.push_back(mv_dir);
            x_idx.push_back(mv_idx);
            $display("xfer edge=%0d idx=%0d dir=%b", cyc + 1, mv_idx, mv_dir);
        end
        prev_valid = mv_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        x_edge.delete(); x_dir.delete(); x_idx.delete(); r_edge.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; comp = 1'b0; btn_play = 1'b0; btn_step = 1'b0; btn_rew = 1'b0; mv_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_log();
    endtask

    task automatic setup3();
        comp = 1'b1; cnt = 5'd3; ord = 44'b10_11_01; mv_ready = 1'b1;
    endtask

    task automatic press_play();
        btn_play = 1'b1; tick(); btn_play = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({mv_valid, mv_dir, mv_idx, busy, done} !== 10'd0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", {mv_valid, mv_dir, mv_idx, busy, done});
        end
    endtask

    task automatic test_basic();
        int b;
        logic [1:0] exp_dir [3] = '{2'b01, 2'b11, 2'b10};
        do_reset(); setup3();
        b = cyc; btn_play = 1'b1;
        repeat (14) tick();   // play held the whole time: one event only
        checks++;
        if (x_edge.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", x_edge.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < x_edge.size() && i < r_edge.size()) begin
                checks++;
                if (x_dir[i] !== exp_dir[i] || x_idx[i] !== 5'(i)) begin
                    failures++; $display("FAIL basic_move%0d got=%b/%0d exp=%b/%0d", i, x_dir[i], x_idx[i], exp_dir[i], i);
                end
                checks++;
                if (r_edge[i] !== ((i == 0) ? b + 1 : x_edge[i-1] + 4)) begin
                    failures++; $display("FAIL basic_rise%0d got=%0d exp=%0d", i, r_edge[i], (i == 0) ? b + 1 : x_edge[i-1] + 4);
                end
            end
        end
        checks++;
        if ({done, busy, mv_valid, mv_idx} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
            failures++; $display("FAIL basic_done got=%b exp=%b", {done, busy, mv_valid, mv_idx}, {1'b1, 1'b0, 1'b0, 5'd3});
        end
        btn_play = 1'b0; btn_rew = 1'b1; tick(); btn_rew = 1'b0;
        checks++;
        if (done !== 1'b0 || mv_idx !== 5'd0) begin
            failures++; $display("FAIL done_rewind got=%b/%0d exp=0/0", done, mv_idx);
        end
    endtask

    task automatic test_backpressure();
        int b, bad, n1;
        do_reset(); setup3();
        b = cyc; press_play();
        while (cyc < b + 6) tick();
        mv_ready = 1'b0; bad = 0;
        repeat (5) begin
            tick();
            if (!(mv_valid === 1'b1 && mv_dir === 2'b11 && mv_idx === 5'd1)) bad++;
        end
        mv_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad exp=0_bad", bad); end
        n1 = 0;
        foreach (x_idx[i]) if (x_idx[i] == 5'd1) n1++;
        checks++;
        if (x_edge.size() != 3 || n1 != 1) begin
            failures++; $display("FAIL bp_xfers got=%0d/%0d exp=3/1", x_edge.size(), n1);
        end
        checks++;
        if (x_edge.size() >= 2 && x_edge[1] !== b + 12) begin
            failures++; $display("FAIL bp_edge got=%0d exp=%0d", x_edge[1], b + 12);
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done); end
    endtask

    task automatic test_pause_step();
        int bad, s, p;
        do_reset(); setup3();
        press_play(); tick(); tick();
        press_play();                       // pause during the gap after move 0
        bad = 0;
        repeat (20) begin
            tick();
            if (mv_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || x_edge.size() != 1) begin
            failures++; $display("FAIL pause_hold got=%0d_bad/%0d exp=0_bad/1", bad, x_edge.size());
        end
        s = cyc; btn_step = 1'b1; tick(); btn_step = 1'b0;
        checks++;
        if ({mv_valid, mv_dir, mv_idx} !== {1'b1, 2'b11, 5'd1}) begin
            failures++; $display("FAIL step_issue got=%b exp=%b", {mv_valid, mv_dir, mv_idx}, {1'b1, 2'b11, 5'd1});
        end
        repeat (7) tick();
        checks++;
        if (x_edge.size() != 2 || mv_valid !== 1'b0 || busy !== 1'b1 || mv_idx !== 5'd2) begin
            failures++; $display("FAIL step_paused got=%0d/%b/%b/%0d exp=2/0/1/2", x_edge.size(), mv_valid, busy, mv_idx);
        end
        p = cyc; press_play();
        repeat (6) tick();
        checks++;
        if (r_edge.size() != 3 || x_edge.size() != 3 || done !== 1'b1) begin
            failures++; $display("FAIL resume_count got=%0d/%0d/%b exp=3/3/1", r_edge.size(), x_edge.size(), done);
        end else begin
            checks++;
            if (r_edge[2] !== p + 5) begin failures++; $display("FAIL resume_rise got=%0d exp=%0d", r_edge[2], p + 5); end
        end
        if (s == 0) $display("note: step at cycle 0");
    endtask

    task automatic test_resume_frozen();
        int p;
        do_reset(); setup3();
        press_play(); tick(); tick();
        press_play();                       // frozen with two gap clocks still pending
        repeat (3) tick();
        p = cyc; press_play();
        repeat (4) tick();
        checks++;
        if (r_edge.size() != 2 || (r_edge.size() == 2 && r_edge[1] !== p + 4)) begin
            failures++; $display("FAIL frozen_gap got=%0d exp=%0d", (r_edge.size() == 2) ? r_edge[1] : -1, p + 4);
        end
    endtask

    task automatic test_rewind_issue();
        int b;
        do_reset(); setup3();
        b = cyc; press_play();
        while (cyc < b + 6) tick();
        mv_ready = 1'b0;
        checks++;
        if (mv_valid !== 1'b1 || mv_idx !== 5'd1) begin failures++; $display("FAIL rew_pre got=%b/%0d exp=1/1", mv_valid, mv_idx); end
        tick();
        btn_rew = 1'b1; tick(); btn_rew = 1'b0;
        tick(); tick();
        checks++;
        if (mv_valid !== 1'b1 || mv_idx !== 5'd1) begin failures++; $display("FAIL rew_held got=%b/%0d exp=1/1", mv_valid, mv_idx); end
        mv_ready = 1'b1; tick();
        checks++;
        if ({mv_valid, mv_idx, busy, done} !== 8'd0) begin
            failures++; $display("FAIL rew_idle got=%b exp=0", {mv_valid, mv_idx, busy, done});
        end
        repeat (6) tick();
        checks++;
        if (x_edge.size() != 2 || mv_valid !== 1'b0) begin
            failures++; $display("FAIL rew_xfers got=%0d/%b exp=2/0", x_edge.size(), mv_valid);
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        comp = 1'b1; cnt = 5'd0; ord = '1; mv_ready = 1'b1;
        press_play();
        checks++;
        if ({done, mv_valid, busy, mv_idx} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            failures++; $display("FAIL len0_done got=%b exp=%b", {done, mv_valid, busy, mv_idx}, {1'b1, 1'b0, 1'b0, 5'd0});
        end
        repeat (3) tick();
        checks++;
        if (r_edge.size() != 0) begin failures++; $display("FAIL len0_valid got=%0d exp=0", r_edge.size()); end
    endtask

    task automatic test_clamp();
        logic [43:0] ord_ref;
        int bad, n;
        do_reset();
        ord_ref = 44'hA5C3F096E1D;
        comp = 1'b1; cnt = 5'd31; ord = ord_ref; mv_ready = 1'b1;
        press_play();
        cnt = 5'd1; ord = '0;               // ignored until the next return to idle
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (done !== 1'b1 || x_edge.size() != 22) begin
            failures++; $display("FAIL clamp_count got=%b/%0d exp=1/22", done, x_edge.size());
        end
        bad = 0;
        foreach (x_dir[i]) if (x_dir[i] !== ord_ref[2*i +: 2] || x_idx[i] !== 5'(i)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clamp_moves got=%0d_bad exp=0_bad", bad); end
        checks++;
        if (x_idx.size() == 0 || x_idx[$] !== 5'd21 || mv_idx !== 5'd22) begin
            failures++; $display("FAIL clamp_last got=%0d/%0d exp=21/22", (x_idx.size() == 0) ? -1 : int'(x_idx[$]), mv_idx);
        end
    endtask

    task automatic test_comp_fall();
        do_reset(); setup3();
        press_play(); tick(); tick();
        press_play();
        checks++;
        if (busy !== 1'b1 || mv_idx !== 5'd1) begin failures++; $display("FAIL cf_pre got=%b/%0d exp=1/1", busy, mv_idx); end
        comp = 1'b0; tick();
        checks++;
        if ({busy, done, mv_valid, mv_idx} !== 8'd0) begin
            failures++; $display("FAIL cf_idle got=%b exp=0", {busy, done, mv_valid, mv_idx});
        end
    endtask

    task automatic test_async_reset();
        do_reset(); setup3();
        press_play(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || mv_idx !== 5'd1 || mv_dir !== 2'b01) begin
            failures++; $display("FAIL ar_pre got=%b/%0d/%b exp=1/1/01", busy, mv_idx, mv_dir);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mv_valid, mv_dir, mv_idx, busy, done} !== 10'd0) begin
            failures++; $display("FAIL ar_async got=%b exp=0", {mv_valid, mv_dir, mv_idx, busy, done});
        end
        tick(); rst_n = 1'b1; tick();
        clear_log();
        press_play();
        repeat (2) tick();
        checks++;
        if (x_edge.size() < 1 || x_idx[0] !== 5'd0 || x_dir[0] !== 2'b01) begin
            failures++; $display("FAIL ar_restart got=%0d exp=1_xfer_idx0_dir01", x_edge.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pause_step();
        test_resume_frozen();
        test_rewind_issue();
        test_len_zero();
        test_clamp();
        test_comp_fall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
